// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART TX-side arbitration logic.
package uart_pkg;

    // Arbiter state: waiting for a requester, or a grant is held.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Bits needed to hold a counter value in 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin first-set search: starting at ptr and wrapping,
// return the first index whose req bit is set.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int pos;

    // Scan from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX queue write port between several
// byte-stream requesters. A grant is held for a whole message, bounded by a
// burst limit and an idle timeout so no requester can starve the others.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_queue_full,
    output logic                          tx_queue_we,
    output logic [DATA_WIDTH-1:0]         tx_queue_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam int IDLE_W  = cnt_width(IDLE_TIMEOUT);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);

    arb_state_t           state_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [IDX_W-1:0]     gidx_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [BURST_W-1:0]   burst_cnt_reg;
    logic [IDLE_W-1:0]    idle_cnt_reg;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  busy_state;
    logic                  valid_g;
    logic                  last_g;
    logic                  beat;
    logic                  release_now;

    // Unpack the flat data bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Beat and release decode for the current owner; write path has no added latency.
    always_comb begin
        busy_state  = (state_reg == ARB_BUSY);
        valid_g     = req_valid[gidx_reg];
        last_g      = req_last[gidx_reg];
        beat        = busy_state & valid_g & ~tx_queue_full;
        // A full queue is backpressure, not idleness, so only a low valid counts.
        release_now = (beat & (last_g | (burst_cnt_reg == BURST_LAST)))
                    | (busy_state & ~valid_g & (idle_cnt_reg == IDLE_LAST));
    end

    assign busy           = busy_state;
    assign grant          = grant_reg;
    assign tx_queue_we    = beat;
    assign req_ready      = beat ? grant_reg : '0;
    assign tx_queue_wdata = busy_state ? data_arr[gidx_reg] : '0;

    // Arbitration FSM: grant on the cycle after a request, release after the message.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            gidx_reg      <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_reg     <= ARB_BUSY;
                        grant_reg     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        gidx_reg      <= pick_idx;
                        burst_cnt_reg <= '0;
                        idle_cnt_reg  <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (beat) begin
                        burst_cnt_reg <= burst_cnt_reg + 1'b1;
                        idle_cnt_reg  <= '0;
                    end else if (!valid_g && idle_cnt_reg < IDLE_MAX) begin
                        idle_cnt_reg  <= idle_cnt_reg + 1'b1;
                    end
                    if (release_now) begin
                        state_reg  <= ARB_IDLE;
                        grant_reg  <= '0;
                        rr_ptr_reg <= (gidx_reg == LAST_IDX) ? '0 : gidx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

    // At most one owner at any time.
    grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_reg));

endmodule
